// File: rtl/rot_reservation_station_pkg.sv
// Shared types for the rotate-unit reservation station.
//   rotate_decode_t : decoded rotate/shift/mask-insert control word
//   operand_t       : source operand with ready flag and producer tag
//   rot_rs_entry_t  : one reservation-station slot
//   rs_capture()    : CDB snoop helper used at dispatch and during wakeup
package rot_reservation_station_pkg;

    localparam int TAG_WIDTH = 6;

    typedef enum logic [1:0] {
        ROT_RLWINM = 2'd0,
        ROT_RLWNM  = 2'd1,
        ROT_RLWIMI = 2'd2,
        ROT_SHIFT  = 2'd3
    } rot_op_e;

    typedef struct packed {
        rot_op_e    op;
        logic       mask_insert;  // op merges into the old target value
        logic [4:0] sh;
        logic [4:0] mb;
        logic [4:0] me;
        logic       rc;
    } rotate_decode_t;

    typedef struct packed {
        logic                 valid;
        logic [TAG_WIDTH-1:0] tag;
        logic [0:31]          value;
    } operand_t;

    typedef struct packed {
        logic           busy;
        rotate_decode_t control;
        logic [4:0]     result_reg_addr;
        operand_t       op1;
        operand_t       op2;
        operand_t       target;
        logic [31:0]    xer;
    } rot_rs_entry_t;

    // A still-pending operand whose tag matches a live broadcast takes the value.
    function automatic operand_t rs_capture(
        input operand_t             op,
        input logic                 cdb_valid,
        input logic [TAG_WIDTH-1:0] cdb_tag,
        input logic [31:0]          cdb_value
    );
        operand_t res;
        res = op;
        if (!op.valid && cdb_valid && (op.tag == cdb_tag)) begin
            res.valid = 1'b1;
            res.value = cdb_value;
        end else begin
            res = op;
        end
        return res;
    endfunction

endpackage

// File: rtl/rot_reservation_station_if.sv
// Dispatch, CDB and issue buses of the rotate reservation station.
//   master : dispatcher / CDB source / rotate-unit side (drives requests)
//   slave  : the reservation station itself
interface rot_reservation_station_if
    import rot_reservation_station_pkg::*;
#(
    parameter int RS_ID_WIDTH = 2
);
    // dispatch
    logic                   dispatch_valid;
    logic                   dispatch_ready;
    rotate_decode_t         dispatch_control;
    logic [4:0]             dispatch_result_reg_addr;
    operand_t               dispatch_op1;
    operand_t               dispatch_op2;
    operand_t               dispatch_target;
    logic [31:0]            dispatch_xer;
    // common data bus
    logic                   cdb_valid;
    logic [TAG_WIDTH-1:0]   cdb_tag;
    logic [31:0]            cdb_value;
    // issue to rotate unit
    logic                   issue_valid;
    logic                   issue_ready;
    logic [RS_ID_WIDTH-1:0] issue_rs_id;
    logic [4:0]             issue_result_reg_addr;
    logic [31:0]            issue_op1;
    logic [31:0]            issue_op2;
    logic [31:0]            issue_target;
    logic [31:0]            issue_xer;
    rotate_decode_t         issue_control;

    modport slave (
        input  dispatch_valid, dispatch_control, dispatch_result_reg_addr,
               dispatch_op1, dispatch_op2, dispatch_target, dispatch_xer,
               cdb_valid, cdb_tag, cdb_value, issue_ready,
        output dispatch_ready, issue_valid, issue_rs_id, issue_result_reg_addr,
               issue_op1, issue_op2, issue_target, issue_xer, issue_control
    );

    modport master (
        output dispatch_valid, dispatch_control, dispatch_result_reg_addr,
               dispatch_op1, dispatch_op2, dispatch_target, dispatch_xer,
               cdb_valid, cdb_tag, cdb_value, issue_ready,
        input  dispatch_ready, issue_valid, issue_rs_id, issue_result_reg_addr,
               issue_op1, issue_op2, issue_target, issue_xer, issue_control
    );
endinterface

// File: rtl/rot_reservation_station_prio_encoder.sv
// Lowest-index priority encoder.
//   i_req : request vector
//   o_idx : index of the lowest set bit (0 when none set)
//   o_any : at least one bit set
module prio_encoder #(
    parameter int WIDTH = 4,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] i_req,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);
    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        o_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            o_idx = i_req[i] ? IDX_W'(i) : o_idx;
        end
        o_any = |i_req;
    end
endmodule

// File: rtl/rot_reservation_station.sv
// Reservation station in front of the rotate/shift unit.
//   clk, rst : clock and synchronous active-high reset
//   bus      : dispatch in, CDB snoop in, issue out (slave modport)
// Entries wait for their operands by snooping the CDB; the lowest-index
// fully-ready entry is offered to the rotate unit, its index being the rs_id.
module rot_reservation_station
    import rot_reservation_station_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int RS_ID_WIDTH = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    rot_reservation_station_if.slave  bus
);
    rot_rs_entry_t          r_entries [DEPTH];
    logic [DEPTH-1:0]       w_free;
    logic [DEPTH-1:0]       w_ready;
    logic [RS_ID_WIDTH-1:0] w_alloc_idx;
    logic [RS_ID_WIDTH-1:0] w_issue_idx;
    logic                   w_any_free;
    logic                   w_any_ready;
    logic                   w_dispatch_fire;
    logic                   w_issue_fire;
    operand_t               w_dispatch_target;
    rot_rs_entry_t          w_new_entry;

    // Per-entry free and ready vectors, from registered state only.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_free[i]  = ~r_entries[i].busy;
            w_ready[i] = r_entries[i].busy & r_entries[i].op1.valid &
                         r_entries[i].op2.valid & r_entries[i].target.valid;
        end
    end

    prio_encoder #(.WIDTH(DEPTH), .IDX_W(RS_ID_WIDTH)) u_alloc_sel (
        .i_req (w_free),
        .o_idx (w_alloc_idx),
        .o_any (w_any_free)
    );

    prio_encoder #(.WIDTH(DEPTH), .IDX_W(RS_ID_WIDTH)) u_issue_sel (
        .i_req (w_ready),
        .o_idx (w_issue_idx),
        .o_any (w_any_ready)
    );

    // A slot freed by this cycle's issue is not counted, keeping ready->ready paths out.
    assign bus.dispatch_ready = ~rst & w_any_free;
    assign bus.issue_valid    = ~rst & w_any_ready;
    assign w_dispatch_fire    = bus.dispatch_valid & bus.dispatch_ready;
    assign w_issue_fire       = bus.issue_valid & bus.issue_ready;

    assign bus.issue_rs_id           = w_issue_idx;
    assign bus.issue_control         = r_entries[w_issue_idx].control;
    assign bus.issue_result_reg_addr = r_entries[w_issue_idx].result_reg_addr;
    assign bus.issue_op1             = r_entries[w_issue_idx].op1.value;
    assign bus.issue_op2             = r_entries[w_issue_idx].op2.value;
    assign bus.issue_target          = r_entries[w_issue_idx].target.value;
    assign bus.issue_xer             = r_entries[w_issue_idx].xer;

    // Build the incoming entry: target unused unless mask-insert, plus same-cycle CDB forwarding.
    always_comb begin
        w_dispatch_target = bus.dispatch_target;
        if (!bus.dispatch_control.mask_insert) begin
            w_dispatch_target.valid = 1'b1;
        end else begin
            w_dispatch_target.valid = bus.dispatch_target.valid;
        end
        w_new_entry.busy            = 1'b1;
        w_new_entry.control         = bus.dispatch_control;
        w_new_entry.result_reg_addr = bus.dispatch_result_reg_addr;
        w_new_entry.op1    = rs_capture(bus.dispatch_op1, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
        w_new_entry.op2    = rs_capture(bus.dispatch_op2, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
        w_new_entry.target = rs_capture(w_dispatch_target, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
        w_new_entry.xer    = bus.dispatch_xer;
    end

    // Entry storage: allocation, CDB wakeup and release on issue handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i].busy <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                // Allocation only ever hits a free entry, never the issuing one.
                if (w_dispatch_fire && (w_alloc_idx == RS_ID_WIDTH'(i))) begin
                    r_entries[i] <= w_new_entry;
                end else if (r_entries[i].busy) begin
                    r_entries[i].op1    <= rs_capture(r_entries[i].op1, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
                    r_entries[i].op2    <= rs_capture(r_entries[i].op2, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
                    r_entries[i].target <= rs_capture(r_entries[i].target, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
                    r_entries[i].busy   <= ~(w_issue_fire && (w_issue_idx == RS_ID_WIDTH'(i)));
                end else begin
                    r_entries[i] <= r_entries[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_rot_reservation_station.sv
// Self-checking bench: directed scenarios followed by random traffic, all
// compared every cycle against a slot-level reference model of the station.
module tb_rot_reservation_station;
    import rot_reservation_station_pkg::*;

    localparam int DEPTH = 4;
    localparam int IDW   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    rot_reservation_station_if #(.RS_ID_WIDTH(IDW)) rs_if ();

    rot_reservation_station #(.DEPTH(DEPTH), .RS_ID_WIDTH(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (rs_if)
    );

    always #5 clk = ~clk;

    // Reference model: each slot holds an op waiting for three values.
    bit             m_busy [DEPTH];
    bit             m_have [DEPTH][3];
    logic [5:0]     m_tag  [DEPTH][3];
    logic [31:0]    m_val  [DEPTH][3];
    rotate_decode_t m_ctrl [DEPTH];
    logic [4:0]     m_rd   [DEPTH];
    logic [31:0]    m_xer  [DEPTH];

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    function automatic operand_t opnd(input bit v, input int tag, input logic [31:0] val);
        operand_t o;
        o.valid = v;
        o.tag   = tag[5:0];
        o.value = val;
        return o;
    endfunction

    function automatic rotate_decode_t ctl(input bit mi);
        rotate_decode_t c;
        c.op          = mi ? ROT_RLWIMI : ROT_RLWINM;
        c.mask_insert = mi;
        c.sh          = 5'd0;
        c.mb          = 5'd0;
        c.me          = 5'd31;
        c.rc          = 1'b0;
        return c;
    endfunction

    // One cycle: compare outputs with the model, advance the model, cross the edge.
    task automatic tick();
        int  exp_id;
        int  slot;
        bit  exp_iv;
        bit  exp_dr;
        operand_t inops [3];
        #1;
        exp_dr = 1'b0;
        exp_iv = 1'b0;
        exp_id = 0;
        slot   = -1;
        for (int e = DEPTH - 1; e >= 0; e--) begin
            if (!m_busy[e]) slot = e;
            if (m_busy[e] && m_have[e][0] && m_have[e][1] && m_have[e][2]) begin
                exp_iv = 1'b1;
                exp_id = e;
            end
        end
        exp_dr = !rst && (slot >= 0);
        exp_iv = !rst && exp_iv;
        chk("dispatch_ready", rs_if.dispatch_ready, exp_dr);
        chk("issue_valid", rs_if.issue_valid, exp_iv);
        if (exp_iv) begin
            chk("issue_rs_id", rs_if.issue_rs_id, exp_id);
            chk("issue_op1", rs_if.issue_op1, m_val[exp_id][0]);
            chk("issue_op2", rs_if.issue_op2, m_val[exp_id][1]);
            if (m_ctrl[exp_id].mask_insert)
                chk("issue_target", rs_if.issue_target, m_val[exp_id][2]);
            chk("issue_xer", rs_if.issue_xer, m_xer[exp_id]);
            chk("issue_rd", rs_if.issue_result_reg_addr, m_rd[exp_id]);
            chk("issue_control", rs_if.issue_control, m_ctrl[exp_id]);
        end
        if (rst) begin
            for (int e = 0; e < DEPTH; e++) m_busy[e] = 1'b0;
        end else begin
            for (int e = 0; e < DEPTH; e++)
                for (int k = 0; k < 3; k++)
                    if (m_busy[e] && !m_have[e][k] && rs_if.cdb_valid && m_tag[e][k] == rs_if.cdb_tag) begin
                        m_have[e][k] = 1'b1;
                        m_val[e][k]  = rs_if.cdb_value;
                    end
            if (exp_iv && rs_if.issue_ready) m_busy[exp_id] = 1'b0;
            if (rs_if.dispatch_valid && exp_dr) begin
                inops[0] = rs_if.dispatch_op1;
                inops[1] = rs_if.dispatch_op2;
                inops[2] = rs_if.dispatch_target;
                m_busy[slot] = 1'b1;
                m_ctrl[slot] = rs_if.dispatch_control;
                m_rd[slot]   = rs_if.dispatch_result_reg_addr;
                m_xer[slot]  = rs_if.dispatch_xer;
                for (int k = 0; k < 3; k++) begin
                    m_have[slot][k] = inops[k].valid || (k == 2 && !rs_if.dispatch_control.mask_insert);
                    m_tag[slot][k]  = inops[k].tag;
                    m_val[slot][k]  = inops[k].value;
                    if (!m_have[slot][k] && rs_if.cdb_valid && inops[k].tag == rs_if.cdb_tag) begin
                        m_have[slot][k] = 1'b1;
                        m_val[slot][k]  = rs_if.cdb_value;
                    end
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic dispatch(input operand_t o1, input operand_t o2, input operand_t tg, input bit mi);
        rs_if.dispatch_valid           = 1'b1;
        rs_if.dispatch_op1             = o1;
        rs_if.dispatch_op2             = o2;
        rs_if.dispatch_target          = tg;
        rs_if.dispatch_control         = ctl(mi);
        rs_if.dispatch_result_reg_addr = 5'($urandom_range(0, 31));
        rs_if.dispatch_xer             = $urandom;
    endtask

    task automatic cdb(input bit v, input int tag, input logic [31:0] val);
        rs_if.cdb_valid = v;
        rs_if.cdb_tag   = tag[5:0];
        rs_if.cdb_value = val;
    endtask

    initial begin
        for (int e = 0; e < DEPTH; e++) m_busy[e] = 1'b0;
        rs_if.dispatch_valid = 1'b0;
        rs_if.issue_ready    = 1'b0;
        dispatch(opnd(1'b0, 0, 32'h0), opnd(1'b0, 0, 32'h0), opnd(1'b0, 0, 32'h0), 1'b0);
        rs_if.dispatch_valid = 1'b0;
        cdb(1'b0, 0, 32'h0);
        @(negedge clk);

        // Reset
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("post_reset_dispatch_ready", rs_if.dispatch_ready, 1'b1);
        chk("post_reset_issue_valid", rs_if.issue_valid, 1'b0);

        // Ready dispatch issues one cycle later from entry 0
        rs_if.issue_ready = 1'b1;
        dispatch(opnd(1'b1, 0, 32'h8000_0001), opnd(1'b1, 0, 32'h1), opnd(1'b0, 0, 32'h0), 1'b0);
        tick();
        rs_if.dispatch_valid = 1'b0;
        #1;
        chk("ready_issue_valid", rs_if.issue_valid, 1'b1);
        chk("ready_rs_id", rs_if.issue_rs_id, 2'd0);
        chk("ready_op1", rs_if.issue_op1, 32'h8000_0001);
        tick();
        #1;
        chk("ready_released", rs_if.issue_valid, 1'b0);

        // Pending operand woken by the CDB
        dispatch(opnd(1'b0, 5, 32'h0), opnd(1'b1, 0, 32'h7), opnd(1'b0, 0, 32'h0), 1'b0);
        tick();
        rs_if.dispatch_valid = 1'b0;
        tick();
        cdb(1'b1, 5, 32'h1234_5678);
        tick();
        cdb(1'b0, 0, 32'h0);
        #1;
        chk("wakeup_issue_valid", rs_if.issue_valid, 1'b1);
        chk("wakeup_op1", rs_if.issue_op1, 32'h1234_5678);
        tick();

        // Same-cycle forwarding at dispatch
        dispatch(opnd(1'b1, 0, 32'hF0), opnd(1'b0, 9, 32'h0), opnd(1'b0, 0, 32'h0), 1'b0);
        cdb(1'b1, 9, 32'h3);
        tick();
        rs_if.dispatch_valid = 1'b0;
        cdb(1'b0, 0, 32'h0);
        #1;
        chk("fwd_issue_valid", rs_if.issue_valid, 1'b1);
        chk("fwd_op2", rs_if.issue_op2, 32'h3);
        tick();

        // Fill all entries, wake 2 then 1 with issue held off
        rs_if.issue_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            dispatch(opnd(1'b0, 20 + k, 32'h0), opnd(1'b1, 0, 32'(k)), opnd(1'b0, 0, 32'h0), 1'b0);
            tick();
        end
        rs_if.dispatch_valid = 1'b0;
        #1;
        chk("full_dispatch_ready", rs_if.dispatch_ready, 1'b0);
        chk("full_issue_valid", rs_if.issue_valid, 1'b0);
        tick();
        cdb(1'b1, 22, 32'hAA);
        tick();
        cdb(1'b1, 21, 32'hBB);
        tick();
        cdb(1'b0, 0, 32'h0);
        #1;
        chk("fill_rs_id_first", rs_if.issue_rs_id, 2'd1);
        chk("fill_op1_first", rs_if.issue_op1, 32'hBB);
        rs_if.issue_ready = 1'b1;
        tick();
        #1;
        chk("fill_dispatch_ready_after_issue", rs_if.dispatch_ready, 1'b1);
        chk("fill_rs_id_second", rs_if.issue_rs_id, 2'd2);
        tick();
        cdb(1'b1, 20, 32'hC0);
        tick();
        cdb(1'b1, 23, 32'hC3);
        tick();
        cdb(1'b0, 0, 32'h0);
        tick();
        tick();

        // Target gating
        dispatch(opnd(1'b1, 0, 32'h11), opnd(1'b1, 0, 32'h2), opnd(1'b0, 40, 32'h0), 1'b0);
        tick();
        rs_if.dispatch_valid = 1'b0;
        #1;
        chk("nomask_issue_valid", rs_if.issue_valid, 1'b1);
        tick();
        dispatch(opnd(1'b1, 0, 32'h22), opnd(1'b1, 0, 32'h4), opnd(1'b0, 41, 32'h0), 1'b1);
        tick();
        rs_if.dispatch_valid = 1'b0;
        tick();
        tick();
        #1;
        chk("mask_waits", rs_if.issue_valid, 1'b0);
        cdb(1'b1, 41, 32'h55);
        tick();
        cdb(1'b0, 0, 32'h0);
        #1;
        chk("mask_issue_valid", rs_if.issue_valid, 1'b1);
        chk("mask_target", rs_if.issue_target, 32'h55);
        tick();

        // Reset with three ready entries, one being issued
        rs_if.issue_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            dispatch(opnd(1'b1, 0, 32'(k + 100)), opnd(1'b1, 0, 32'h1), opnd(1'b0, 0, 32'h0), 1'b0);
            tick();
        end
        rs_if.dispatch_valid = 1'b0;
        #1;
        chk("pre_reset_issue_valid", rs_if.issue_valid, 1'b1);
        rs_if.issue_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk("in_reset_issue_valid", rs_if.issue_valid, 1'b0);
        chk("in_reset_dispatch_ready", rs_if.dispatch_ready, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        chk("after_reset_dispatch_ready", rs_if.dispatch_ready, 1'b1);
        chk("after_reset_issue_valid", rs_if.issue_valid, 1'b0);
        tick();
        tick();

        // Random traffic against the model
        for (int n = 0; n < 800; n++) begin
            dispatch(opnd($urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom),
                     opnd($urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom),
                     opnd($urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom),
                     $urandom_range(0, 1) == 1);
            rs_if.dispatch_valid = ($urandom_range(0, 2) != 0);
            cdb($urandom_range(0, 1) == 1, $urandom_range(0, 9), $urandom);
            rs_if.issue_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 149) == 0);
            tick();
        end
        rst = 1'b0;
        rs_if.dispatch_valid = 1'b0;
        cdb(1'b0, 0, 32'h0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
